// File: rtl/ps2_mouse_pkg.sv
// Shared types, command/response codes and the init script ROM for the PS/2 mouse controller.
// Define MOUSE_WHEEL_EN to build the IntelliMouse knock and ID read into the script.
package ps2_mouse_pkg;

   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_SET_RATE = 8'hF3;
   localparam logic [7:0] CMD_GET_ID   = 8'hF2;
   localparam logic [7:0] RSP_ACK      = 8'hFA;
   localparam logic [7:0] RSP_BAT      = 8'hAA;
   localparam logic [7:0] RSP_RESEND   = 8'hFE;
   localparam logic [7:0] RSP_ID_STD   = 8'h00;
   localparam logic [7:0] RSP_ID_WHEEL = 8'h03;

   localparam int IDX_W = 5;
   // Step expecting the device ID byte right after BAT; hot-plug re-entry point.
   localparam logic [IDX_W-1:0] IDX_BAT_ID = 5'd3;

   typedef enum logic [2:0] {
      S_TX, S_EXP, S_B0, S_B1, S_B2, S_B3, S_APPLY
   } mouse_state_t;

   typedef enum logic [1:0] {
      OP_TX, OP_EXP, OP_ID, OP_STREAM
   } script_op_t;

   typedef struct packed {
      script_op_t op;
      logic [7:0] code;
   } script_step_t;

   typedef struct packed {
      logic       y_ovf;
      logic       x_ovf;
      logic       y_sgn;
      logic       x_sgn;
      logic       sync;
      logic       btn_m;
      logic       btn_r;
      logic       btn_l;
      logic [7:0] dx;
      logic [7:0] dy;
      logic [7:0] dz;
   } mouse_packet_t;

   function automatic script_step_t script_rom(input logic [IDX_W-1:0] idx);
      script_step_t s;
      s = '{OP_STREAM, 8'h00};
      case (idx)
         5'd0:  s = '{OP_TX,  CMD_RESET};
         5'd1:  s = '{OP_EXP, RSP_ACK};
         5'd2:  s = '{OP_EXP, RSP_BAT};
         5'd3:  s = '{OP_EXP, RSP_ID_STD};
`ifdef MOUSE_WHEEL_EN
         5'd4:  s = '{OP_TX,  CMD_SET_RATE};
         5'd5:  s = '{OP_EXP, RSP_ACK};
         5'd6:  s = '{OP_TX,  8'hC8};
         5'd7:  s = '{OP_EXP, RSP_ACK};
         5'd8:  s = '{OP_TX,  CMD_SET_RATE};
         5'd9:  s = '{OP_EXP, RSP_ACK};
         5'd10: s = '{OP_TX,  8'h64};
         5'd11: s = '{OP_EXP, RSP_ACK};
         5'd12: s = '{OP_TX,  CMD_SET_RATE};
         5'd13: s = '{OP_EXP, RSP_ACK};
         5'd14: s = '{OP_TX,  8'h50};
         5'd15: s = '{OP_EXP, RSP_ACK};
         5'd16: s = '{OP_TX,  CMD_GET_ID};
         5'd17: s = '{OP_EXP, RSP_ACK};
         5'd18: s = '{OP_ID,  8'h00};
         5'd19: s = '{OP_TX,  CMD_ENABLE};
         5'd20: s = '{OP_EXP, RSP_ACK};
`else
         5'd4:  s = '{OP_TX,  CMD_ENABLE};
         5'd5:  s = '{OP_EXP, RSP_ACK};
`endif
         default: s = '{OP_STREAM, 8'h00};
      endcase
      return s;
   endfunction

   function automatic mouse_state_t step_state(input script_op_t op);
      case (op)
         OP_TX:     return S_TX;
         OP_STREAM: return S_B0;
         default:   return S_EXP;
      endcase
   endfunction

endpackage

// File: rtl/ps2_mouse_cursor_accum.sv
// One cursor axis: sign-extends a 9-bit PS/2 delta, adds or subtracts it, clamps to 0..MAX_POS.
module ps2_mouse_cursor_accum #(
   parameter int POS_W    = 10,
   parameter int MAX_POS  = 639,
   parameter int INIT_POS = 100
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             neg,
   input  logic [8:0]       delta,
   output logic [POS_W-1:0] pos
);
   localparam int SW = POS_W + 2;
   localparam logic signed [SW-1:0] MAX_S = SW'(MAX_POS);

   logic signed [SW-1:0] ext, cur, sum;
   logic [POS_W-1:0]     pos_n;

   // Two guard bits keep the sum exact so the clamp never sees a wrapped value.
   always_comb begin
      ext = {{(SW-9){delta[8]}}, delta};
      cur = {2'b00, pos};
      sum = neg ? (cur - ext) : (cur + ext);
      if (sum[SW-1])
         pos_n = '0;
      else if (sum > MAX_S)
         pos_n = POS_W'(MAX_POS);
      else
         pos_n = sum[POS_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pos <= POS_W'(INIT_POS);
      else if (en)
         pos <= pos_n;
   end

endmodule

// File: rtl/ps2_mouse_ctrl.sv
// PS/2 mouse host: runs the init script over the byte-level tx/rx pair, then decodes stream packets
// into a clamped cursor. Define MOUSE_WHEEL_EN for the IntelliMouse knock and 4-byte wheel packets.
module ps2_mouse_ctrl
   import ps2_mouse_pkg::*;
#(
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int POS_W       = 10,
   parameter int INIT_X      = 100,
   parameter int INIT_Y      = 100,
   parameter int TIMEOUT_CYC = 2_000_000
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             rx_done_tick,
   input  logic [7:0]       rx_dout,
   input  logic             tx_done_tick,
   output logic             wr_ps2,
   output logic [7:0]       din,
   output logic [POS_W-1:0] cursor_x,
   output logic [POS_W-1:0] cursor_y,
   output logic [2:0]       buttons,
   output logic [3:0]       wheel,
   output logic             pkt_valid,
   output logic             init_done,
   output logic             err_tick
);
   localparam int TO_W = $clog2(TIMEOUT_CYC);

   mouse_state_t     state, state_n;
   logic [IDX_W-1:0] idx, idx_n, last_tx, last_tx_n;
   logic [1:0]       retry, retry_n;
   logic [TO_W-1:0]  to_cnt;
   logic             timeout, to_clr, jump, apply, err_n, init_err, rx_match;
   mouse_packet_t    pkt, pkt_n;
   script_step_t     step, nxt_step;
   logic [8:0]       dx, dy;
   logic             unused_bits;
`ifdef MOUSE_WHEEL_EN
   logic             four_byte, four_n;
`endif

   assign step    = script_rom(idx);
   assign timeout = (to_cnt == TO_W'(TIMEOUT_CYC - 1));

`ifdef MOUSE_WHEEL_EN
   assign rx_match = (step.op == OP_ID) ? (rx_dout == RSP_ID_STD || rx_dout == RSP_ID_WHEEL)
                                        : (rx_dout == step.code);
`else
   assign rx_match = (rx_dout == step.code);
`endif

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      last_tx_n = last_tx;
      retry_n   = retry;
      pkt_n     = pkt;
      err_n     = 1'b0;
      init_err  = 1'b0;
      apply     = 1'b0;
      jump      = 1'b0;
`ifdef MOUSE_WHEEL_EN
      four_n    = four_byte;
`endif
      case (state)
         S_TX: begin
            last_tx_n = idx;
            if (tx_done_tick) begin
               idx_n = idx + IDX_W'(1);
               jump  = 1'b1;
            end else if (timeout) begin
               init_err = 1'b1;
            end
         end
         S_EXP: begin
            if (rx_done_tick) begin
               if (rx_match) begin
                  idx_n   = idx + IDX_W'(1);
                  retry_n = '0;
                  jump    = 1'b1;
`ifdef MOUSE_WHEEL_EN
                  if (step.op == OP_ID) four_n = (rx_dout == RSP_ID_WHEEL);
`endif
               end else if (rx_dout == RSP_RESEND && retry != 2'd3) begin
                  retry_n = retry + 2'd1;
                  idx_n   = last_tx;
                  jump    = 1'b1;
               end else begin
                  init_err = 1'b1;
               end
            end else if (timeout) begin
               init_err = 1'b1;
            end
         end
         S_B0: begin
            // Idle mouse is legal here, so no timeout; AA means the device was re-plugged.
            if (rx_done_tick) begin
               if (rx_dout == RSP_BAT) begin
                  idx_n   = IDX_BAT_ID;
                  retry_n = '0;
                  jump    = 1'b1;
               end else if (!rx_dout[3]) begin
                  err_n = 1'b1;
               end else begin
                  pkt_n[31:24] = rx_dout;
                  pkt_n.dz     = 8'h00;
                  state_n      = S_B1;
               end
            end
         end
         S_B1: begin
            if (rx_done_tick) begin
               pkt_n.dx = rx_dout;
               state_n  = S_B2;
            end else if (timeout) begin
               err_n   = 1'b1;
               state_n = S_B0;
            end
         end
         S_B2: begin
            if (rx_done_tick) begin
               pkt_n.dy = rx_dout;
`ifdef MOUSE_WHEEL_EN
               state_n  = four_byte ? S_B3 : S_APPLY;
`else
               state_n  = S_APPLY;
`endif
            end else if (timeout) begin
               err_n   = 1'b1;
               state_n = S_B0;
            end
         end
`ifdef MOUSE_WHEEL_EN
         S_B3: begin
            if (rx_done_tick) begin
               pkt_n.dz = rx_dout;
               state_n  = S_APPLY;
            end else if (timeout) begin
               err_n   = 1'b1;
               state_n = S_B0;
            end
         end
`endif
         S_APPLY: begin
            apply   = 1'b1;
            state_n = S_B0;
         end
         default: state_n = S_TX;
      endcase

      if (init_err) begin
         err_n   = 1'b1;
         idx_n   = '0;
         retry_n = '0;
         jump    = 1'b1;
      end
      nxt_step = script_rom(idx_n);
      if (jump) state_n = step_state(nxt_step.op);
   end

   assign to_clr = rx_done_tick | jump | (state_n != state);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (to_clr)
         to_cnt <= '0;
      else if (!timeout)
         to_cnt <= to_cnt + TO_W'(1);
   end

   // Outputs are registered from next-state so wr_ps2 is low throughout reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_TX;
         idx       <= '0;
         last_tx   <= '0;
         retry     <= '0;
         pkt       <= '0;
         wr_ps2    <= 1'b0;
         din       <= 8'h00;
         init_done <= 1'b0;
         err_tick  <= 1'b0;
         pkt_valid <= 1'b0;
         buttons   <= 3'b000;
      end else begin
         state     <= state_n;
         idx       <= idx_n;
         last_tx   <= last_tx_n;
         retry     <= retry_n;
         pkt       <= pkt_n;
         wr_ps2    <= (state_n == S_TX);
         din       <= (state_n == S_TX) ? nxt_step.code : 8'h00;
         init_done <= (state_n inside {S_B0, S_B1, S_B2, S_B3, S_APPLY});
         err_tick  <= err_n;
         pkt_valid <= apply;
         if (apply) buttons <= {pkt.btn_m, pkt.btn_r, pkt.btn_l};
      end
   end

`ifdef MOUSE_WHEEL_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         four_byte <= 1'b0;
         wheel     <= 4'd0;
      end else begin
         four_byte <= four_n;
         if (apply) wheel <= four_byte ? pkt.dz[3:0] : 4'd0;
      end
   end
   assign unused_bits = ^{pkt.sync, pkt.dz[7:4]};
`else
   assign wheel       = 4'd0;
   assign unused_bits = ^{pkt.sync, pkt.dz};
`endif

   // An overflowed axis contributes nothing rather than a garbage delta.
   assign dx = pkt.x_ovf ? 9'd0 : {pkt.x_sgn, pkt.dx};
   assign dy = pkt.y_ovf ? 9'd0 : {pkt.y_sgn, pkt.dy};

   ps2_mouse_cursor_accum #(
      .POS_W(POS_W), .MAX_POS(SCREEN_W - 1), .INIT_POS(INIT_X)
   ) u_acc_x (
      .clk(clk), .rst(rst), .en(apply), .neg(1'b0), .delta(dx), .pos(cursor_x)
   );

   ps2_mouse_cursor_accum #(
      .POS_W(POS_W), .MAX_POS(SCREEN_H - 1), .INIT_POS(INIT_Y)
   ) u_acc_y (
      .clk(clk), .rst(rst), .en(apply), .neg(1'b1), .delta(dy), .pos(cursor_y)
   );

endmodule

// File: tb/tb_ps2_mouse_ctrl.sv
// Scoreboard bench for ps2_mouse_ctrl: a driver feeds init/packet bytes and queues expectations,
// a negedge monitor pops and compares tx commands, packets and error pulses.
module tb_ps2_mouse_ctrl;
   localparam int SW = 640;
   localparam int SH = 480;
   localparam int TO = 64;

   logic       clk = 1'b0, rst = 1'b1;
   logic       rx_done_tick = 1'b0, tx_done_tick = 1'b0;
   logic [7:0] rx_dout = 8'h00;
   logic       wr_ps2, pkt_valid, init_done, err_tick;
   logic [7:0] din;
   logic [9:0] cursor_x, cursor_y;
   logic [2:0] buttons;
   logic [3:0] wheel;

   typedef struct {int x; int y; int btn; int cyc;} exp_pkt_t;
   exp_pkt_t   exp_pkt[$];
   int         exp_err[$];
   logic [7:0] exp_tx[$];
   exp_pkt_t   mon_e;
   logic       wr_q = 1'b0;
   int n_checks = 0, n_pass = 0, cyc = 0, last_rx_cyc = 0;
   int mx = 100, my = 100;

   ps2_mouse_ctrl #(.SCREEN_W(SW), .SCREEN_H(SH), .POS_W(10), .INIT_X(100), .INIT_Y(100),
                    .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst(rst), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
      .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .din(din), .cursor_x(cursor_x),
      .cursor_y(cursor_y), .buttons(buttons), .wheel(wheel), .pkt_valid(pkt_valid),
      .init_done(init_done), .err_tick(err_tick));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : ((v > hi) ? hi : v);
   endfunction

   // Monitor: every DUT-presented event must match the head of its expectation queue.
   always @(negedge clk) begin
      if (rst) wr_q = 1'b0;
      else begin
         if (pkt_valid) begin
            chk("pkt_expected", int'(exp_pkt.size() != 0), 1);
            if (exp_pkt.size() != 0) begin
               mon_e = exp_pkt.pop_front();
               chk("pkt_x", int'(cursor_x), mon_e.x);
               chk("pkt_y", int'(cursor_y), mon_e.y);
               chk("pkt_buttons", int'(buttons), mon_e.btn);
               chk("pkt_wheel", int'(wheel), 0);
               chk("pkt_latency", cyc, mon_e.cyc);
            end
         end
         if (err_tick) begin
            chk("err_expected", int'(exp_err.size() != 0), 1);
            if (exp_err.size() != 0) void'(exp_err.pop_front());
         end
         if (wr_ps2 && !wr_q) begin
            chk("tx_expected", int'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) chk("tx_din", int'(din), int'(exp_tx.pop_front()));
         end
         wr_q = wr_ps2;
      end
   end

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk); #1;
      rx_dout = b;
      rx_done_tick = 1'b1;
      @(posedge clk); #1;
      rx_done_tick = 1'b0;
      last_rx_cyc = cyc;
   endtask

   task automatic service_tx();
      int n = 0;
      while (!wr_ps2 && n < 4 * TO) begin
         @(negedge clk);
         n++;
      end
      chk("tx_request", int'(wr_ps2), 1);
      repeat (2) @(posedge clk);
      #1 tx_done_tick = 1'b1;
      @(posedge clk);
      #1 tx_done_tick = 1'b0;
   endtask

   // Reference: 9-bit signed deltas from the header sign bits, y is up-positive, clamp to screen.
   task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      int dx, dy;
      exp_pkt_t e;
      dx = b0[6] ? 0 : (b0[4] ? int'(b1) - 256 : int'(b1));
      dy = b0[7] ? 0 : (b0[5] ? int'(b2) - 256 : int'(b2));
      mx = clampi(mx + dx, SW - 1);
      my = clampi(my - dy, SH - 1);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      // Last byte sampled at edge N; pkt_valid is high in the cycle after edge N+1.
      e.x = mx; e.y = my; e.btn = int'(b0[2:0]); e.cyc = last_rx_cyc + 1;
      exp_pkt.push_back(e);
      repeat (3) @(posedge clk);
   endtask

   task automatic move_to(input int tx, input int ty);
      int dx, dy;
      logic [8:0] ux, uy;
      for (int k = 0; k < 8 && (mx != tx || my != ty); k++) begin
         dx = tx - mx;
         dy = my - ty;
         if (dx > 255) dx = 255;
         if (dx < -255) dx = -255;
         if (dy > 255) dy = 255;
         if (dy < -255) dy = -255;
         ux = dx[8:0];
         uy = dy[8:0];
         send_pkt({2'b00, uy[8], ux[8], 4'b1000}, ux[7:0], uy[7:0]);
      end
   endtask

   // Script tail from the ID byte after BAT through stream enable.
   task automatic tail_script();
      logic [7:0] cmds[$];
`ifdef MOUSE_WHEEL_EN
      cmds = '{8'hF3, 8'hC8, 8'hF3, 8'h64, 8'hF3, 8'h50, 8'hF2, 8'hF4};
`else
      cmds = '{8'hF4};
`endif
      foreach (cmds[i]) exp_tx.push_back(cmds[i]);
      send_byte(8'h00);
      foreach (cmds[i]) begin
         service_tx();
         send_byte(8'hFA);
         if (cmds[i] == 8'hF2) send_byte(8'h00);
      end
   endtask

   initial begin
      logic [7:0] b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_wr_ps2", int'(wr_ps2), 0);
      chk("rst_din", int'(din), 0);
      chk("rst_cursor_x", int'(cursor_x), 100);
      chk("rst_cursor_y", int'(cursor_y), 100);
      chk("rst_buttons", int'(buttons), 0);
      chk("rst_wheel", int'(wheel), 0);
      chk("rst_init_done", int'(init_done), 0);
      chk("rst_flags", int'({pkt_valid, err_tick}), 0);

      // Init with resends, retry exhaustion, a bad BAT and an ack timeout.
      repeat (7) exp_tx.push_back(8'hFF);
      @(negedge clk) rst = 1'b0;
      service_tx();
      repeat (3) begin
         send_byte(8'hFE);
         service_tx();
      end
      exp_err.push_back(1);
      send_byte(8'hFE);
      service_tx();
      send_byte(8'hFA);
      exp_err.push_back(2);
      send_byte(8'h55);
      service_tx();
      exp_err.push_back(3);
      service_tx();
      send_byte(8'hFA);
      send_byte(8'hAA);
      tail_script();
      @(negedge clk);
      chk("init_done", int'(init_done), 1);

      repeat (3 * TO) @(posedge clk);
      chk("idle_b0_no_err_left", exp_err.size(), 0);

      send_pkt(8'h28, 8'h05, 8'hFD);
      chk("basic_x", int'(cursor_x), 105);
      chk("basic_y", int'(cursor_y), 103);

      for (int i = 0; i < 24; i++) begin
         b0 = 8'($urandom);
         b0[3] = 1'b1;
         if ($urandom_range(0, 3) != 0) b0[7:6] = 2'b00;
         if (b0 == 8'hAA) b0 = 8'h0A;
         send_pkt(b0, 8'($urandom), 8'($urandom));
      end

      move_to(2, 478);
      send_pkt(8'h38, 8'hF0, 8'hF0);
      chk("clamp_x0", int'(cursor_x), 0);
      chk("clamp_ymax", int'(cursor_y), 479);
      send_pkt(8'h08, 8'hFF, 8'h00);
      chk("nowrap_x", int'(cursor_x), 255);

      exp_err.push_back(4);
      send_byte(8'h05);
      send_pkt(8'h08, 8'h0A, 8'h00);

      exp_err.push_back(5);
      send_byte(8'h08);
      repeat (2 * TO) @(posedge clk);
      send_pkt(8'h09, 8'h01, 8'h00);

      send_byte(8'hAA);
      chk("hotplug_init_drop", int'(init_done), 0);
      tail_script();
      @(negedge clk);
      chk("hotplug_init_done", int'(init_done), 1);
      send_pkt(8'h1A, 8'hF8, 8'h04);

      repeat (4) @(posedge clk);
      chk("pending_pkt", exp_pkt.size(), 0);
      chk("pending_err", exp_err.size(), 0);
      chk("pending_tx", exp_tx.size(), 0);

      // Async reset mid-cycle, then again while a command request is held.
      exp_tx.push_back(8'hFF);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_cursor_x", int'(cursor_x), 100);
      chk("arst_cursor_y", int'(cursor_y), 100);
      chk("arst_init_done", int'(init_done), 0);
      @(negedge clk) rst = 1'b0;
      for (int n = 0; n < 20 && !wr_ps2; n++) @(negedge clk);
      chk("arst_wr_up", int'(wr_ps2), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_wr_drop", int'(wr_ps2), 0);
      chk("arst_tx_seen", exp_tx.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
